// File: rtl/dcache_port_arbiter.sv
// rtl/dcache_port_arbiter.sv - round-robin arbiter sharing one D$ port among requesters
// A stalled request stays locked to its port; read responses are routed back through an in-order ID FIFO.
module dcache_port_arbiter #(
  parameter int NR_PORTS   = 3,
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 56
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [NR_PORTS-1:0]        req_i,
  input  logic [NR_PORTS-1:0]        we_i,
  input  logic [NR_PORTS*ADDR_W-1:0] addr_i,
  input  logic [NR_PORTS*64-1:0]     wdata_i,
  input  logic [NR_PORTS*8-1:0]      be_i,
  input  logic [NR_PORTS*2-1:0]      size_i,
  output logic [NR_PORTS-1:0]        gnt_o,
  output logic [NR_PORTS-1:0]        rvalid_o,
  output logic [63:0]                rdata_o,
  output logic                       data_req_o,
  input  logic                       data_gnt_i,
  output logic                       data_we_o,
  output logic [ADDR_W-1:0]          address_o,
  output logic [63:0]                data_wdata_o,
  output logic [7:0]                 data_be_o,
  output logic [1:0]                 data_size_o,
  input  logic                       data_rvalid_i,
  input  logic [63:0]                data_rdata_i,
  output logic                       idle_o,
  output logic                       err_o
);
  localparam int IDX_W = (NR_PORTS > 1) ? $clog2(NR_PORTS) : 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [IDX_W-1:0] rr_q, rr_d, sel_q, sel_d, rr_sel, sel, head;
  logic             lock_q, lock_d, err_q, err_d;
  logic [IDX_W-1:0] fifo_q [FIFO_DEPTH];
  logic [IDX_W-1:0] fifo_d [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [NR_PORTS-1:0] elig;
  logic             any_elig, fifo_full, fifo_empty, grant, push, pop;
  int               scan_idx;

  assign fifo_full  = (cnt_q == CNT_W'(FIFO_DEPTH));
  assign fifo_empty = (cnt_q == '0);
  assign head       = fifo_q[rd_ptr_q];

  // Reads need a free ID slot; writes are never tracked so they are never held off.
  always_comb begin
    any_elig = 1'b0;
    rr_sel   = rr_q;
    scan_idx = 0;
    for (int i = 0; i < NR_PORTS; i++) begin
      elig[i] = req_i[i] && (we_i[i] || !fifo_full);
    end
    for (int k = 0; k < NR_PORTS; k++) begin
      scan_idx = int'(rr_q) + k;
      if (scan_idx >= NR_PORTS) scan_idx = scan_idx - NR_PORTS;
      for (int j = 0; j < NR_PORTS; j++) begin
        if (!any_elig && scan_idx == j && elig[j]) begin
          any_elig = 1'b1;
          rr_sel   = IDX_W'(j);
        end
      end
    end
  end

  assign sel        = lock_q ? sel_q : rr_sel;
  assign data_req_o = lock_q || any_elig;
  assign grant      = data_req_o && data_gnt_i;

  always_comb begin
    data_we_o    = 1'b0;
    address_o    = '0;
    data_wdata_o = '0;
    data_be_o    = '0;
    data_size_o  = '0;
    gnt_o        = '0;
    rvalid_o     = '0;
    for (int i = 0; i < NR_PORTS; i++) begin
      if (data_req_o && sel == IDX_W'(i)) begin
        data_we_o    = we_i[i];
        address_o    = addr_i[i*ADDR_W +: ADDR_W];
        data_wdata_o = wdata_i[i*64 +: 64];
        data_be_o    = be_i[i*8 +: 8];
        data_size_o  = size_i[i*2 +: 2];
      end
      gnt_o[i]    = grant && (sel == IDX_W'(i));
      rvalid_o[i] = pop && (head == IDX_W'(i));
    end
  end

  assign push    = grant && !data_we_o;
  assign pop     = data_rvalid_i && !fifo_empty;
  assign rdata_o = data_rdata_i;
  assign idle_o  = fifo_empty && !lock_q;
  assign err_o   = err_q;

  always_comb begin
    lock_d   = lock_q;
    sel_d    = sel_q;
    rr_d     = rr_q;
    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    err_d    = err_q || (data_rvalid_i && fifo_empty);
    if (data_req_o && !data_gnt_i) begin
      lock_d = 1'b1;
      sel_d  = sel;
    end
    if (grant) begin
      lock_d = 1'b0;
      rr_d   = (sel == IDX_W'(NR_PORTS-1)) ? '0 : sel + IDX_W'(1);
    end
    if (push) begin
      fifo_d[wr_ptr_q] = sel;
      wr_ptr_d         = wr_ptr_q + PTR_W'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (push && !pop) cnt_d = cnt_q + CNT_W'(1);
    else if (pop && !push) cnt_d = cnt_q - CNT_W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_q     <= '0;
      sel_q    <= '0;
      lock_q   <= 1'b0;
      err_q    <= 1'b0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
    end else begin
      rr_q     <= rr_d;
      sel_q    <= sel_d;
      lock_q   <= lock_d;
      err_q    <= err_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
      fifo_q   <= fifo_d;
    end
  end
endmodule
